// File: rtl/axis_result_requant.sv
// Requantizes a wide signed accumulator vector (round, shift, optional ReLU, saturate)
// and streams the narrow lanes out as LANES_PER_BEAT-lane AXI-Stream beats.

module axis_result_requant_lane #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [ACC_WIDTH-1:0] x,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        relu,
  output logic [OUT_WIDTH-1:0]        q
);
  localparam int EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] QMAX = EW'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [EW-1:0] QMIN = -QMAX - EW'(1);

  logic signed [EW-1:0] xe, rnd, sum, t, tr;

  always_comb begin
    // one extra bit keeps x + rnd from overflowing
    xe  = {x[ACC_WIDTH-1], x};
    rnd = '0;
    if (shift != '0) rnd = EW'(1) << (shift - SHIFT_WIDTH'(1));
    sum = xe + rnd;
    t   = sum >>> shift;
    tr  = (relu && t[EW-1]) ? '0 : t;
    if (tr > QMAX)      q = QMAX[OUT_WIDTH-1:0];
    else if (tr < QMIN) q = QMIN[OUT_WIDTH-1:0];
    else                q = tr[OUT_WIDTH-1:0];
  end
endmodule

module axis_result_requant #(
  parameter int KERNEL_SIZE    = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_WIDTH      = 8,
  parameter int LANES_PER_BEAT = 4,
  parameter int SHIFT_WIDTH    = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SHIFT_WIDTH-1:0]               cfg_shift,
  input  logic                                 cfg_relu,
  input  logic [KERNEL_SIZE*ACC_WIDTH-1:0]     s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [LANES_PER_BEAT*OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [15:0]                          frame_cnt
);
  localparam int NBEATS = KERNEL_SIZE / LANES_PER_BEAT;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [15:0] frame_n;
  logic tvalid_n, tlast_n, load;
  logic [KERNEL_SIZE-1:0][OUT_WIDTH-1:0] qlanes, lane_buf;

  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
    axis_result_requant_lane #(
      .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x(s_axis_tdata[i*ACC_WIDTH +: ACC_WIDTH]),
      .shift(cfg_shift),
      .relu(cfg_relu),
      .q(qlanes[i])
    );
  end

  // refill on the last-beat handshake keeps back-to-back vectors bubble-free
  assign s_axis_tready = !rst && (state == IDLE || (m_axis_tready && m_axis_tlast));

  always_comb begin
    state_n  = state;
    beat_n   = beat_cnt;
    frame_n  = frame_cnt;
    load     = 1'b0;
    case (state)
      IDLE: if (s_axis_tvalid) begin
        load    = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (m_axis_tready) begin
        if (m_axis_tlast) begin
          frame_n = 16'(frame_cnt + 16'd1);
          if (s_axis_tvalid) load = 1'b1;
          else               state_n = IDLE;
        end else begin
          beat_n = BW'(beat_cnt + BW'(1));
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) beat_n = '0;
    tvalid_n = (state_n == BUSY);
    tlast_n  = (state_n == BUSY) && (beat_n == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      frame_cnt     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      lane_buf      <= '0;
    end else begin
      state         <= state_n;
      beat_cnt      <= beat_n;
      frame_cnt     <= frame_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      if (load) lane_buf <= qlanes;
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int j = 0; j < LANES_PER_BEAT; j++)
      m_axis_tdata[j*OUT_WIDTH +: OUT_WIDTH] = lane_buf[int'(beat_cnt)*LANES_PER_BEAT + j];
  end
endmodule

// File: tb/tb_axis_result_requant.sv
// Directed bench for axis_result_requant: rounding, saturation, ReLU, streaming,
// backpressure against a reference model, and reset mid-vector.

module tb_axis_result_requant;
  typedef int lanes_t [16];
  typedef logic [31:0] beats_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b0;
  logic m_axis_tlast;
  logic [15:0] frame_cnt;

  int vec = 0;
  int err = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  axis_result_requant dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_cnt(frame_cnt)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [511:0] pack(input lanes_t l);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = l[i];
    return r;
  endfunction

  function automatic logic [7:0] quant(input int x, input int sh, input bit rl);
    longint t;
    t = x;
    if (sh > 0) t = t + (64'sd1 <<< (sh - 1));
    t = t >>> sh;
    if (rl && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t[7:0];
  endfunction

  // send one vector with m_tready held high and collect its four beats
  task automatic xfer(input lanes_t l, input int sh, input bit rl, input bit tog,
                      output beats_t b, output logic [3:0] tl);
    int n;
    s_axis_tdata = pack(l); cfg_shift = sh[4:0]; cfg_relu = rl;
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; #1;
    n = 0;
    while (!s_axis_tready && n < 20) begin tick(); #1; n++; end
    vec++;
    if (!s_axis_tready) begin err++; $display("FAIL xfer_accept: tready=%b want 1", s_axis_tready); end
    tick();
    s_axis_tvalid = 1'b0;
    if (tog) begin cfg_relu = ~rl; cfg_shift = '0; end
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!m_axis_tvalid && n < 20) begin tick(); #1; n++; end
      vec++;
      if (!m_axis_tvalid) begin err++; $display("FAIL xfer_beat%0d: tvalid=%b want 1", i, m_axis_tvalid); end
      b[i] = m_axis_tdata; tl[i] = m_axis_tlast;
      tick(); #1;
    end
    exp_frames++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); #1;
    vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL rst_sready: got %b want 0", s_axis_tready); end
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL rst_mvalid: got %b want 0", m_axis_tvalid); end
    vec++; if (m_axis_tlast !== 1'b0) begin err++; $display("FAIL rst_mlast: got %b want 0", m_axis_tlast); end
    vec++; if (m_axis_tdata !== 32'h0) begin err++; $display("FAIL rst_mdata: got %h want 0", m_axis_tdata); end
    vec++; if (frame_cnt !== 16'd0) begin err++; $display("FAIL rst_frame: got %0d want 0", frame_cnt); end
    tick(); rst = 1'b0; exp_frames = 0; #1;
    vec++; if (s_axis_tready !== 1'b1) begin err++; $display("FAIL rst_release_sready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_rounding();
    lanes_t l; beats_t b; logic [3:0] tl;
    l = '{default: 0}; l[0] = 24; l[1] = -24; l[2] = 7; l[3] = -8;
    xfer(l, 4, 1'b0, 1'b0, b, tl);
    vec++; if (b[0] !== 32'h0000FF02) begin err++; $display("FAIL round_beat0: got %h want 0000ff02", b[0]); end
    for (int i = 1; i < 4; i++) begin
      vec++; if (b[i] !== 32'h0) begin err++; $display("FAIL round_beat%0d: got %h want 0", i, b[i]); end
    end
    vec++; if (tl !== 4'b1000) begin err++; $display("FAIL round_tlast: got %b want 1000", tl); end
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL round_idle: tvalid=%b want 0", m_axis_tvalid); end
    vec++; if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL round_frame: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_saturation();
    lanes_t l; beats_t b; logic [3:0] tl;
    l = '{default: 0}; l[0] = 4096; l[1] = -4096;
    xfer(l, 4, 1'b0, 1'b0, b, tl);
    vec++; if (b[0] !== 32'h0000807F) begin err++; $display("FAIL sat_pm4096: got %h want 0000807f", b[0]); end
    l = '{default: 0}; l[0] = 32'h7FFFFFFF;
    xfer(l, 31, 1'b0, 1'b0, b, tl);
    vec++; if (b[0] !== 32'h00000001) begin err++; $display("FAIL sat_max_sh31: got %h want 00000001", b[0]); end
    l = '{default: 0}; l[0] = -1;
    xfer(l, 0, 1'b0, 1'b0, b, tl);
    vec++; if (b[0] !== 32'h000000FF) begin err++; $display("FAIL sat_m1_sh0: got %h want 000000ff", b[0]); end
    vec++; if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL sat_frame: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_relu();
    lanes_t l; beats_t b; logic [3:0] tl;
    l = '{default: 0}; l[0] = -24; l[1] = 24; l[4] = -24; l[5] = 24;
    xfer(l, 4, 1'b1, 1'b1, b, tl);
    vec++; if (b[0] !== 32'h00000200) begin err++; $display("FAIL relu_beat0: got %h want 00000200", b[0]); end
    vec++; if (b[1] !== 32'h00000200) begin err++; $display("FAIL relu_cfg_toggle: got %h want 00000200", b[1]); end
    cfg_relu = 1'b0;
  endtask

  task automatic test_back_to_back();
    lanes_t l [3];
    logic [31:0] w;
    for (int v = 0; v < 3; v++)
      for (int i = 0; i < 16; i++) l[v][i] = (v*16 + i) * 16;
    cfg_shift = 5'd4; cfg_relu = 1'b0; m_axis_tready = 1'b1;
    s_axis_tdata = pack(l[0]); s_axis_tvalid = 1'b1; #1;
    vec++; if (s_axis_tready !== 1'b1) begin err++; $display("FAIL b2b_first_ready: got %b want 1", s_axis_tready); end
    tick();
    for (int c = 0; c < 12; c++) begin
      if (c % 4 == 3) begin
        if (c / 4 < 2) s_axis_tdata = pack(l[c/4 + 1]);
        else           s_axis_tvalid = 1'b0;
      end
      #1;
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'((c/4)*16 + (c%4)*4 + j);
      vec++; if (m_axis_tvalid !== 1'b1) begin err++; $display("FAIL b2b_valid c%0d: got %b want 1", c, m_axis_tvalid); end
      vec++; if (m_axis_tdata !== w) begin err++; $display("FAIL b2b_data c%0d: got %h want %h", c, m_axis_tdata, w); end
      vec++; if (s_axis_tready !== (c % 4 == 3)) begin err++; $display("FAIL b2b_sready c%0d: got %b want %b", c, s_axis_tready, (c % 4 == 3)); end
      tick();
    end
    exp_frames += 3; #1;
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL b2b_end_valid: got %b want 0", m_axis_tvalid); end
    vec++; if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL b2b_frame: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_backpressure();
    logic [32:0] expq [$];
    logic [32:0] e;
    lanes_t l;
    logic [31:0] d, prev_d;
    logic prev_l, prev_stall, acc;
    int sent, cyc, sh;
    bit rl;
    sent = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    s_axis_tvalid = 1'b0;
    while ((sent < 4 || expq.size() > 0) && cyc < 3000) begin
      if (!s_axis_tvalid && sent < 4) begin
        for (int i = 0; i < 16; i++) l[i] = int'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 8191) - 4096);
        sh = (sent == 3) ? 31 : int'($urandom_range(0, 9)); rl = bit'($urandom_range(0, 1));
        s_axis_tdata = pack(l); cfg_shift = sh[4:0]; cfg_relu = rl; s_axis_tvalid = 1'b1;
      end
      m_axis_tready = 1'($urandom_range(0, 1)); #1;
      if (prev_stall) begin
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
          err++; $display("FAIL bp_stall_hold: got v%b %h l%b want v1 %h l%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vec++;
        if (expq.size() == 0) begin err++; $display("FAIL bp_extra_beat: got %h want none", m_axis_tdata); end
        else begin
          e = expq.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            err++; $display("FAIL bp_beat: got l%b %h want l%b %h", m_axis_tlast, m_axis_tdata, e[32], e[31:0]);
          end
          if (e[32]) exp_frames++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata; prev_l = m_axis_tlast;
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) begin
        for (int b = 0; b < 4; b++) begin
          for (int j = 0; j < 4; j++) d[j*8 +: 8] = quant(l[b*4 + j], sh, rl);
          expq.push_back({(b == 3), d});
        end
        sent++;
      end
      tick();
      if (acc) s_axis_tvalid = 1'b0;
      cyc++;
    end
    m_axis_tready = 1'b1;
    vec++; if (cyc >= 3000) begin err++; $display("FAIL bp_timeout: sent %0d pending %0d want all drained", sent, expq.size()); end
    #1;
    vec++; if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL bp_frame: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_reset_mid();
    lanes_t l; beats_t b; logic [3:0] tl;
    for (int i = 0; i < 16; i++) l[i] = i * 16;
    s_axis_tdata = pack(l); cfg_shift = 5'd4; cfg_relu = 1'b0;
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    tick(); s_axis_tvalid = 1'b0; #1;
    vec++; if (m_axis_tdata !== 32'h03020100) begin err++; $display("FAIL rmid_beat0: got %h want 03020100", m_axis_tdata); end
    tick(); tick();
    rst = 1'b1; #1;
    vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL rmid_sready: got %b want 0", s_axis_tready); end
    tick();
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL rmid_valid: got %b want 0", m_axis_tvalid); end
    vec++; if (frame_cnt !== 16'd0) begin err++; $display("FAIL rmid_frame: got %0d want 0", frame_cnt); end
    rst = 1'b0; exp_frames = 0;
    xfer(l, 4, 1'b0, 1'b0, b, tl);
    vec++; if (b[0] !== 32'h03020100) begin err++; $display("FAIL rmid_new0: got %h want 03020100", b[0]); end
    vec++; if (b[1] !== 32'h07060504) begin err++; $display("FAIL rmid_new1: got %h want 07060504", b[1]); end
    vec++; if (b[2] !== 32'h0B0A0908) begin err++; $display("FAIL rmid_new2: got %h want 0b0a0908", b[2]); end
    vec++; if (b[3] !== 32'h0F0E0D0C) begin err++; $display("FAIL rmid_new3: got %h want 0f0e0d0c", b[3]); end
    vec++; if (tl !== 4'b1000) begin err++; $display("FAIL rmid_tlast: got %b want 1000", tl); end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL rmid_frame_after: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_relu();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
